// File: rtl/spi_master_if.sv
// spi_master_if: start/operand handshake, status and SPI pin bundle between a host and spi_master.
interface spi_master_if;
  logic        start;
  logic [3:0]  addr_in;
  logic [7:0]  data_in;
  logic        busy;
  logic        done;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic [11:0] rx_data;
  modport master (
    input  start, addr_in, data_in, miso,
    output busy, done, sclk, cs_n, mosi, rx_data
  );
  modport slave (
    output start, addr_in, data_in, miso,
    input  busy, done, sclk, cs_n, mosi, rx_data
  );
endinterface

// File: rtl/spi_master.sv
// spi_master: SPI register-write master sending 14-bit {0,addr,data,0} frames; miso readback of {addr,data} enabled by SPI_MASTER_READBACK_EN.
module spi_master #(
  parameter int unsigned HALF_PERIOD = 4
) (
  input logic          clk,
  input logic          rst_n,
  spi_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, END} state_t;
  localparam logic [7:0] HP_LAST = 8'(HALF_PERIOD - 1);
  localparam logic [3:0] LAST_PULSE = 4'd14;
  state_t      state, state_nxt;
  logic [7:0]  hp_cnt;
  logic [3:0]  pulse;
  logic [3:0]  addr_q;
  logic [7:0]  data_q;
  logic        sclk_q, cs_n_q, mosi_q, busy_q, done_q;
  logic [13:0] frame;
  logic        tick, fall;
  assign frame = {1'b0, addr_q, data_q, 1'b0};
  assign tick  = hp_cnt == 8'd0;
  assign fall  = state == SHIFT && tick && sclk_q;
  assign bus.sclk = sclk_q;
  assign bus.cs_n = cs_n_q;
  assign bus.mosi = mosi_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // Next state: each timed phase ends when the half-period counter reaches zero.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.start ? SETUP : IDLE;
      SETUP:   state_nxt = tick ? SHIFT : SETUP;
      SHIFT:   state_nxt = fall && pulse == LAST_PULSE ? HOLD : SHIFT;
      HOLD:    state_nxt = tick ? END : HOLD;
      END:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // Half-period timer, pulse counter, latched operands and the flop-driven SPI pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_cnt <= '0;
      pulse  <= '0;
      addr_q <= '0;
      data_q <= '0;
      sclk_q <= 1'b0;
      cs_n_q <= 1'b1;
      mosi_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          hp_cnt <= HP_LAST;
          pulse  <= '0;
          addr_q <= bus.addr_in;
          data_q <= bus.data_in;
          cs_n_q <= 1'b0;
          busy_q <= 1'b1;
        end
        SETUP: begin
          hp_cnt <= tick ? HP_LAST : hp_cnt - 8'd1;
          if (tick) begin
            pulse  <= 4'd1;
            mosi_q <= frame[13];
          end
        end
        SHIFT: begin
          hp_cnt <= tick ? HP_LAST : hp_cnt - 8'd1;
          if (tick) sclk_q <= !sclk_q;
          if (fall && pulse != LAST_PULSE) begin
            pulse  <= pulse + 4'd1;
            mosi_q <= frame[4'd13 - pulse];
          end
        end
        HOLD: hp_cnt <= tick ? HP_LAST : hp_cnt - 8'd1;
        END: begin
          hp_cnt <= '0;
          pulse  <= '0;
          cs_n_q <= 1'b1;
          mosi_q <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`ifdef SPI_MASTER_READBACK_EN
  logic [11:0] rx_sr, rx_q;
  logic        rise;
  assign rise = state == SHIFT && tick && !sclk_q;
  assign bus.rx_data = rx_q;
  // Shift in miso on the rising edges of pulses 1..12 and publish the word as the frame ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr <= '0;
      rx_q  <= '0;
    end else begin
      if (rise && pulse <= 4'd12) rx_sr <= {rx_sr[10:0], bus.miso};
      if (state == END) rx_q <= rx_sr;
    end
  end
`else
  logic unused_miso;
  assign unused_miso = bus.miso;
  assign bus.rx_data = '0;
`endif
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master at HALF_PERIOD 4 plus a HALF_PERIOD 2 timing run.
module tb_spi_master;
  localparam int HP = 4;
  localparam int FRAME_LEN = 2 + 30 * HP;
`ifdef SPI_MASTER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  typedef struct { logic [3:0] addr; logic [7:0] data; logic [13:0] bits; logic [11:0] rx; } vec_t;
  typedef struct { logic [13:0] bits; logic [11:0] rx; int t0; } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0, checks = 0, errors = 0, ndone = 0, stray = 0, last_gap = 0;
  exp_t sb[$];
  vec_t tab[5];
  spi_master_if a();
  spi_master_if b();
  spi_master #(.HALF_PERIOD(HP)) dut4 (.clk(clk), .rst_n(rst_n), .bus(a));
  spi_master #(.HALF_PERIOD(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b));
  assign b.miso = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // slave model: echoes the previous complete frame's {addr,data} on miso, MSB first
  logic [11:0] sl_prev, sl_cap;
  logic [3:0]  sl_n;
  logic        sl_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      sl_prev = '0; sl_cap = '0; sl_n = '0;
    end else if (a.cs_n) begin
      if (sl_n == 4'd14) sl_prev = sl_cap;
      sl_n = '0;
    end else if (a.sclk && !sl_last) begin
      sl_n = sl_n + 4'd1;
      if (sl_n >= 4'd2 && sl_n <= 4'd13) sl_cap = {sl_cap[10:0], a.mosi};
    end
    sl_last = a.sclk;
    a.miso = sl_n < 4'd12 ? sl_prev[4'd11 - sl_n] : 1'b0;
  end

  // monitor: collects mosi bits and phase widths of dut4, pops the scoreboard at done
  logic prev_sclk, prev_mosi, prev_cs;
  logic [13:0] bits;
  int run, pulses, width_err, mosi_err, hi;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_sclk = 1'b0; prev_mosi = 1'b0; prev_cs = 1'b1; hi = 0; run = 0;
    end else begin
      if (!a.cs_n) begin
        if (prev_cs) begin
          last_gap = hi; pulses = 0; bits = '0; width_err = 0; mosi_err = 0; run = 0;
        end
        if (a.sclk != prev_sclk) begin
          if (run != ((prev_sclk || pulses > 0) ? HP : 2 * HP)) width_err++;
          run = 0;
          if (a.sclk) begin
            pulses++;
            bits = {bits[12:0], a.mosi};
          end
        end
        run++;
        if (a.mosi != prev_mosi && !(prev_sclk && !a.sclk)) mosi_err++;
        hi = 0;
      end else begin
        if (!prev_cs && run != HP + 1) width_err++;
        if (a.sclk) stray++;
        hi++;
      end
      if (a.done) begin
        ndone++;
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("mosi_bits", bits, e.bits);
          chk("pulse_count", pulses, 14);
          chk("frame_len", cyc - e.t0, FRAME_LEN);
          chk("phase_width", width_err, 0);
          chk("mosi_stable", mosi_err, 0);
          chk("rx_data", a.rx_data, e.rx);
          chk("busy_at_done", a.busy, 0);
          chk("cs_n_at_done", a.cs_n, 1);
        end
      end
      prev_sclk = a.sclk; prev_mosi = a.mosi; prev_cs = a.cs_n;
    end
  end

  task automatic send(input vec_t v, input bit push);
    exp_t e;
    a.addr_in = v.addr; a.data_in = v.data; a.start = 1'b1;
    e.bits = v.bits; e.rx = RB ? v.rx : 12'h0; e.t0 = cyc;
    if (push) sb.push_back(e);
    @(negedge clk);
    a.start = 1'b0;
    chk("busy_after_start", a.busy, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!a.done && n < 400) begin @(negedge clk); n++; end
    chk("done_seen", a.done, 1);
  endtask

  initial begin
    int t0, k, rises, r2, n2, bad2;
    logic p, p2;
    logic [13:0] bits2;
    tab[0] = '{4'hA, 8'h5C, 14'b01010010111000, 12'h000};
    tab[1] = '{4'h6, 8'h81, 14'b00110100000010, 12'hA5C};
    tab[2] = '{4'h0, 8'h00, 14'b00000000000000, 12'h681};
    tab[3] = '{4'hF, 8'hFF, 14'b01111111111110, 12'h000};
    tab[4] = '{4'h9, 8'hA5, 14'b01001101001010, 12'hFFF};
    a.start = 1'b0; a.addr_in = '0; a.data_in = '0;
    b.start = 1'b0; b.addr_in = '0; b.data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", a.sclk, 0);
    chk("rst_cs_n", a.cs_n, 1);
    chk("rst_mosi", a.mosi, 0);
    chk("rst_busy", a.busy, 0);
    chk("rst_done", a.done, 0);
    chk("rst_rx", a.rx_data, 0);
    chk("rst_cs_n_hp2", b.cs_n, 1);
    rst_n = 1'b1;
    // back-to-back table frames, each start issued in the done cycle
    for (int i = 0; i < 5; i++) begin
      send(tab[i], 1'b1);
      wait_done();
      if (i > 0) chk("cs_gap", last_gap, 1);
    end
    repeat (2) @(negedge clk);
    // start during busy and start in the END cycle are both ignored
    t0 = cyc;
    send('{4'hA, 8'h5C, 14'b01010010111000, 12'h9A5}, 1'b1);
    repeat (20) @(negedge clk);
    a.addr_in = 4'h3; a.data_in = 8'hFF; a.start = 1'b1;
    @(negedge clk);
    a.start = 1'b0;
    while (cyc < t0 + FRAME_LEN - 1) @(negedge clk);
    a.start = 1'b1;
    @(negedge clk);
    a.start = 1'b0;
    chk("done_after_ignored", a.done, 1);
    repeat (3) @(negedge clk);
    chk("end_start_busy", a.busy, 0);
    chk("end_start_cs_n", a.cs_n, 1);
    // reset during pulse 7 aborts, first edge after release accepts a clean frame
    send('{4'h3, 8'hFF, 14'b00011111111110, 12'h000}, 1'b0);
    rises = 0; k = 0; p = 1'b0;
    while (rises < 7 && k < 500) begin
      @(negedge clk);
      k++;
      if (a.sclk && !p) rises++;
      p = a.sclk;
    end
    chk("reached_pulse7", rises, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_sclk", a.sclk, 0);
    chk("abort_cs_n", a.cs_n, 1);
    chk("abort_busy", a.busy, 0);
    chk("abort_mosi", a.mosi, 0);
    repeat (3) @(negedge clk);
    chk("abort_hold_sclk", a.sclk, 0);
    chk("abort_hold_cs_n", a.cs_n, 1);
    rst_n = 1'b1;
    send('{4'h3, 8'hFF, 14'b00011111111110, 12'h000}, 1'b1);
    wait_done();
    repeat (2) @(negedge clk);
    // HALF_PERIOD 2 instance: phase widths, pulse count, bits and frame length
    b.addr_in = 4'h5; b.data_in = 8'h3C; b.start = 1'b1; t0 = cyc;
    @(negedge clk);
    b.start = 1'b0;
    r2 = 0; n2 = 0; bad2 = 0; k = 0; p2 = 1'b0; bits2 = '0;
    while (!b.done && k < 200) begin
      if (!b.cs_n) begin
        if (b.sclk != p2) begin
          if (r2 != ((p2 || n2 > 0) ? 2 : 4)) bad2++;
          r2 = 0;
          if (b.sclk) begin n2++; bits2 = {bits2[12:0], b.mosi}; end
        end
        r2++;
      end
      p2 = b.sclk;
      @(negedge clk);
      k++;
    end
    chk("hp2_done", b.done, 1);
    chk("hp2_len", cyc - t0, 62);
    chk("hp2_pulses", n2, 14);
    chk("hp2_phase", bad2, 0);
    chk("hp2_bits", bits2, 14'b00101001111000);
    repeat (4) @(negedge clk);
    chk("done_count", ndone, 7);
    chk("stray_sclk", stray, 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 4: clk cycles per sclk half-period; legal range 2..255.
REQ-002 SHALL have port clk  input  1  system clock; all logic rises on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to send one frame.
REQ-005 SHALL have port addr_in  input  4  register address to write.
REQ-006 SHALL have port data_in  input  8  register data to write.
REQ-007 SHALL have port busy  output  1  high from accepted start until frame end.
REQ-008 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-009 SHALL have port sclk  output  1  SPI clock; idle low.
REQ-010 SHALL have port cs_n  output  1  chip select; active low.
REQ-011 SHALL have port mosi  output  1  serial data to slave.
REQ-012 SHALL have port miso  input  1  serial data from slave.
REQ-013 SHALL have port rx_data  output  12  readback word {addr,data} echoed by slave.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, SHIFT, HOLD, END.
REQ-015 IDLE: start=1 SHALL latch addr_in/data_in, assert busy, drive cs_n low, enter SETUP next cycle.
REQ-016 start while busy=1 SHALL be ignored; latched operands SHALL not change mid-frame.
REQ-017 SETUP SHALL last HALF_PERIOD cycles with sclk low, then enter SHIFT.
REQ-018 SHIFT SHALL generate exactly 14 sclk pulses, each HALF_PERIOD low then HALF_PERIOD high, low phase first.
REQ-019 Bit sent for pulse k (1..14), stable for the whole pulse, changed only while sclk low: k=1 -> 0 (framing dummy); k=2..5 -> addr[3..0] MSB first; k=6..13 -> data[7..0] MSB first; k=14 -> 0 (commit).
REQ-020 Pulse counter SHALL be 4 bits, count 1..14, never wrap within a frame.
REQ-021 After falling edge of pulse 14, HOLD SHALL keep sclk low, cs_n low for HALF_PERIOD cycles.
REQ-022 END SHALL drive cs_n high, mosi 0, pulse done for one cycle, clear busy, return to IDLE; start in END cycle SHALL be ignored.
REQ-023 Min cs_n-high gap between frames SHALL be 1 clk cycle (start accepted in first IDLE cycle after END).
REQ-024 Half-period counter SHALL reload on every sclk toggle; no sclk glitch shorter than HALF_PERIOD cycles.
REQ-025 sclk, cs_n, mosi SHALL be driven directly from flops.
REQ-026 Total frame length, start to done, SHALL be 2 + 30*HALF_PERIOD cycles.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, sclk 0, cs_n 1, mosi 0, busy 0, done 0, rx_data 0, counters 0.
REQ-028 Reset mid-frame SHALL abort without further sclk edges; no partial frame resumes after release.
REQ-029 First start SHALL be accepted in the first clk edge after rst_n deassertion.

Configuration
REQ-030 With macro SPI_MASTER_READBACK_EN defined, miso SHALL be sampled on rising edges of pulses 1..12 into a shift register, MSB first, and copied to rx_data in END cycle.
REQ-031 Without SPI_MASTER_READBACK_EN, rx_data SHALL be constant 0, miso unused, no sampling logic synthesized.

Verification
REQ-032 HALF_PERIOD=4, start with addr=0xA, data=0x5C -> cs_n low, 14 sclk pulses, mosi bits 0,1010,01011100,0; done at cycle 122.
REQ-033 Start repeated during busy with addr=0x3, data=0xFF -> ignored; first frame bits unchanged, exactly one done.
REQ-034 rst_n low during pulse 7 -> same-cycle sclk 0, cs_n 1, busy 0; next start sends clean full frame.
REQ-035 READBACK_EN, bench slave echoes previous frame: frame1 addr=0x6 data=0x81, frame2 any -> rx_data=0x681 at frame2 done.
REQ-036 Back-to-back: start in cycle after done -> accepted; cs_n high exactly 1 cycle between frames.
REQ-037 HALF_PERIOD=2 -> every sclk high/low phase exactly 2 cycles; frame length 62 cycles.
